// File: rtl/instr_issue_queue.sv
// Instruction issue queue: pairs host bytes into 9-bit instructions, buffers them
// in a FIFO and issues one per cycle with a WRITE_EN strobe and a running fetch PC.
module instr_issue_queue #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned INSTR_W = 9,
    parameter int unsigned PC_STEP = 4
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic [7:0]                 DIN,
    input  logic                       DIN_VALID,
    input  logic                       SYNC,
    input  logic                       CLEAR,
    input  logic                       ISSUE_EN,
    output logic [INSTR_W-1:0]         INSTRUCTION,
    output logic                       WRITE_EN,
    output logic [8:0]                 PC,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic                       FULL,
    output logic                       EMPTY,
    output logic                       OVERFLOW
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned PCW = 9;

    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } phase_t;

    phase_t               phase_q;
    phase_t               phase_d;
    logic [7:0]           held_q;
    logic                 push_c;
    logic                 pop_c;
    logic                 push_ok_c;
    logic                 drop_c;
    logic [CW-1:0]        count_d;
    logic [INSTR_W-1:0]   word_c;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [INSTR_W-1:0]   mem [DEPTH];

    // Byte-phase state register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            phase_q <= PH_LO;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Assembler next-state: CLEAR beats SYNC beats data
    always_comb begin
        phase_d = phase_q;
        push_c  = 1'b0;
        if (CLEAR || SYNC) begin
            phase_d = PH_LO;
        end else if (DIN_VALID) begin
            if (phase_q == PH_LO) begin
                phase_d = PH_HI;
            end else begin
                phase_d = PH_LO;
                push_c  = 1'b1;
            end
        end
    end

    // Low byte held while waiting for the high byte
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            held_q <= 8'h00;
        end else if (!CLEAR && !SYNC && DIN_VALID && (phase_q == PH_LO)) begin
            held_q <= DIN;
        end
    end

    assign word_c    = INSTR_W'({DIN[0], held_q});
    assign pop_c     = !CLEAR && ISSUE_EN && !EMPTY;
    assign push_ok_c = push_c && (!FULL || pop_c);
    assign drop_c    = push_c && FULL && !pop_c;

    // Occupancy next value; a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = COUNT;
        if (CLEAR) begin
            count_d = '0;
        end else if (push_ok_c && !pop_c) begin
            count_d = COUNT + CW'(1);
        end else if (!push_ok_c && pop_c) begin
            count_d = COUNT - CW'(1);
        end
    end

    // Storage array; the read side sees the pre-edge value on a full push+pop
    always_ff @(posedge CLK) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= word_c;
        end
    end

    // Pointers, flags, issue register and PC
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            COUNT       <= '0;
            FULL        <= 1'b0;
            EMPTY       <= 1'b1;
            OVERFLOW    <= 1'b0;
            PC          <= '0;
            WRITE_EN    <= 1'b0;
            INSTRUCTION <= '0;
        end else begin
            COUNT <= count_d;
            FULL  <= (count_d == CW'(DEPTH));
            EMPTY <= (count_d == CW'(0));
            if (CLEAR) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                OVERFLOW <= 1'b0;
                PC       <= '0;
                WRITE_EN <= 1'b0;
            end else begin
                WRITE_EN <= pop_c;
                if (push_ok_c) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop_c) begin
                    rd_ptr      <= rd_ptr + AW'(1);
                    INSTRUCTION <= mem[rd_ptr];
                    PC          <= PC + PCW'(PC_STEP);
                end
                if (drop_c) begin
                    OVERFLOW <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed bench for instr_issue_queue: expected words go into a scoreboard queue
// when their high byte is driven and are matched whenever WRITE_EN is seen.
module tb_instr_issue_queue;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [7:0] DIN;
    logic       DIN_VALID;
    logic       SYNC;
    logic       CLEAR;
    logic       ISSUE_EN;
    logic [8:0] INSTRUCTION;
    logic       WRITE_EN;
    logic [8:0] PC;
    logic [3:0] COUNT;
    logic       FULL;
    logic       EMPTY;
    logic       OVERFLOW;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [8:0] sb [$];
    logic [8:0] exp_w;

    instr_issue_queue #(.DEPTH(8), .INSTR_W(9), .PC_STEP(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .SYNC(SYNC), .CLEAR(CLEAR), .ISSUE_EN(ISSUE_EN),
        .INSTRUCTION(INSTRUCTION), .WRITE_EN(WRITE_EN), .PC(PC),
        .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        DIN       = b;
        DIN_VALID = 1'b1;
        step();
        DIN_VALID = 1'b0;
    endtask

    // Second byte carries bit 8 in DIN[0]; upper bits are junk the DUT must ignore
    task automatic send_word(input logic [8:0] w, input bit expect_accept);
        send_byte(w[7:0]);
        if (expect_accept) sb.push_back(w);
        send_byte({7'b1010101, w[8]});
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (EMPTY && !WRITE_EN && sb.size() == 0) done = 1'b1;
        end
        chk("drain_done", 32'(done), 32'd1);
    endtask

    // Every strobe must match the oldest outstanding expected word
    always @(negedge CLK) begin
        if (RESET_N === 1'b1 && WRITE_EN === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write_en", 32'(INSTRUCTION), 32'h1ff);
            end else begin
                exp_w = sb.pop_front();
                chk("issued_instr", 32'(INSTRUCTION), 32'(exp_w));
            end
        end
    end

    initial begin
        RESET_N = 1'b0; DIN = 8'h00; DIN_VALID = 1'b0;
        SYNC = 1'b0; CLEAR = 1'b0; ISSUE_EN = 1'b1;
        #12;
        chk("rst_count", 32'(COUNT), 32'd0);
        chk("rst_empty", 32'(EMPTY), 32'd1);
        RESET_N = 1'b1;
        step();

        // Reset in the middle of a byte pair drops the held byte
        send_byte(8'h77);
        #2 RESET_N = 1'b0;
        #1;
        chk("rst_instr", 32'(INSTRUCTION), 32'd0);
        chk("rst_we", 32'(WRITE_EN), 32'd0);
        chk("rst_pc", 32'(PC), 32'd0);
        chk("rst_full", 32'(FULL), 32'd0);
        chk("rst_ovf", 32'(OVERFLOW), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        step();
        sb.push_back(9'h12A);
        send_byte(8'h2A);
        send_byte(8'h01);
        drain();
        chk("t1_pc", 32'(PC), 32'd4);

        // Stall and fill, then overflow with a 9th word
        ISSUE_EN = 1'b0;
        for (int i = 0; i < 8; i++) send_word(9'(i), 1'b1);
        chk("t2_full", 32'(FULL), 32'd1);
        chk("t2_count8", 32'(COUNT), 32'd8);
        send_word(9'h0FF, 1'b0);
        chk("t2_ovf", 32'(OVERFLOW), 32'd1);
        chk("t2_count_hold", 32'(COUNT), 32'd8);

        // Push and pop together while full
        send_byte(8'h33);
        sb.push_back(9'h133);
        DIN = 8'h01; DIN_VALID = 1'b1; ISSUE_EN = 1'b1;
        step();
        DIN_VALID = 1'b0;
        chk("t3_count8", 32'(COUNT), 32'd8);
        chk("t3_ovf_hold", 32'(OVERFLOW), 32'd1);
        chk("t3_we", 32'(WRITE_EN), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t2_back_to_back", 32'(WRITE_EN), 32'd1);
        end
        chk("t2_empty", 32'(EMPTY), 32'd1);
        step();
        chk("t2_we_low", 32'(WRITE_EN), 32'd0);
        chk("t2_pc", 32'(PC), 32'd40);

        // SYNC discards a pending low byte, even with DIN_VALID high
        send_byte(8'h55);
        SYNC = 1'b1; DIN = 8'h99; DIN_VALID = 1'b1;
        step();
        SYNC = 1'b0; DIN_VALID = 1'b0;
        sb.push_back(9'h010);
        send_byte(8'h10);
        send_byte(8'h00);
        drain();
        chk("t4_instr", 32'(INSTRUCTION), 32'h010);

        // CLEAR with queued words and OVERFLOW set; a concurrent pop is ignored
        ISSUE_EN = 1'b0;
        for (int i = 0; i < 3; i++) send_word(9'(9'h1A0 + i), 1'b0);
        chk("t6_count3", 32'(COUNT), 32'd3);
        chk("t6_ovf_pre", 32'(OVERFLOW), 32'd1);
        CLEAR = 1'b1; ISSUE_EN = 1'b1;
        step();
        CLEAR = 1'b0;
        chk("t6_count0", 32'(COUNT), 32'd0);
        chk("t6_empty", 32'(EMPTY), 32'd1);
        chk("t6_ovf_clr", 32'(OVERFLOW), 32'd0);
        chk("t6_pc", 32'(PC), 32'd0);
        chk("t6_instr_hold", 32'(INSTRUCTION), 32'h010);
        for (int i = 0; i < 3; i++) begin
            chk("t6_no_we", 32'(WRITE_EN), 32'd0);
            step();
        end

        // PC wraps to 0 after the issue at 508
        for (int i = 0; i < 127; i++) send_word(9'((i * 37 + 5) % 512), 1'b1);
        drain();
        chk("t5_pc508", 32'(PC), 32'd508);
        send_word(9'h1C3, 1'b1);
        drain();
        chk("t5_pc_wrap", 32'(PC), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
